rsc2_enc_parity_pack: RTL and testbench
=======================================

Name: rsc2_enc_parity_pack

Overview:
Downstream stage of the rsc2 encoder Y/W puncture blocks. Accepts the sparse, valid-qualified 2-bit duobit stream that survives puncturing, plus frame start/end markers from encoder frame control. Packs surviving duobits into pDAT_W-bit words with per-word valid count and sop/eop framing, ready for the output mux/FIFO. No backpressure: upstream cannot stall, so every packed word is emitted as a single-cycle oval pulse.

Parameters:
pDAT_W, 8, output word width in bits; even, 2..32; pDAT_W/2 duobits per word
pMSB_FIRST, 0, 0: first duobit of a word at odat[1:0]; 1: first duobit at odat[pDAT_W-1:pDAT_W-2]

Ports:
iclk  in  1  clock
ireset  in  1  reset, asynchronous, active-high
iclkena  in  1  clock enable; low freezes all registers and outputs
isop  in  1  first duobit of frame, qualified by ival
ieop  in  1  last duobit of frame, qualified by ival
ival  in  1  duobit valid (puncture stage oval)
idat  in  2  duobit (puncture stage odat); bit order kept inside each 2-bit slot
oval  out  1  packed word valid, one-cycle pulse
osop  out  1  word is first of frame, qualified by oval
oeop  out  1  word is last of frame, qualified by oval
onum  out  5  valid duobits in word, 1..pDAT_W/2, qualified by oval
odat  out  pDAT_W  packed word; unused slots are zero
oerr  out  1  one-cycle framing error pulse

Behaviour:
- Reset (async): oval, osop, oeop, oerr = 0; odat = 0; onum = 0; fill counter cnt = 0; shift accumulator = 0; state = IDLE; first-word flag = 0.
- FSM: IDLE (waiting for isop), PACK (inside frame). Inputs are sampled only when iclkena = 1 and ival = 1. isop/ieop without ival are ignored.
- IDLE:
  - ival & isop: load duobit into slot 0, cnt = 1, set first-word flag, go to PACK.
  - ival & ~isop: duobit dropped, oerr = 1 next cycle, stay IDLE.
- PACK, ival & ~isop: place duobit into slot cnt, cnt + 1.
- Word complete (cnt reaches pDAT_W/2 including the current duobit):
  - Next cycle: oval = 1, onum = pDAT_W/2, osop = first-word flag.
  - Clear first-word flag; cnt = 0.
- ival & ieop (in PACK, or together with isop in IDLE): flush next cycle with current duobit included.
  - oval = 1, oeop = 1, onum = occupied slots, unused slots zero.
  - osop = first-word flag; go to IDLE; cnt = 0.
- isop & ieop in the same cycle from IDLE: one word, osop = oeop = 1, onum = 1.
- isop while in PACK (missing eop): discard the partial word with no output, oerr = 1 next cycle. Restart the frame with the current duobit in slot 0, cnt = 1, first-word flag set.
- Latency: exactly 1 iclkena cycle from the duobit that completes or ends a word to oval.
- oval, osop, oeop, oerr are pulses: 0 on any enabled cycle with no word or error to emit. odat/onum hold their last value when oval = 0.
- Slot placement:
  - pMSB_FIRST = 0: slot k occupies odat[2k+1:2k].
  - pMSB_FIRST = 1: slot k occupies odat[pDAT_W-1-2k : pDAT_W-2-2k].
  - Within a slot, idat[1] maps to the higher bit.
- Accumulator is cleared after every emitted word, so padding is always zero.
- iclkena = 0: no state change, outputs held at current values (pulses stretch with the enable, matching the upstream puncture convention).
- Reset mid-frame: partial word lost, no output; the next frame needs isop.

Test Plan:
- pDAT_W=8, pMSB_FIRST=0: isop + 8 contiguous duobits 0,1,2,3,0,1,2,3, ieop on the 8th -> two words odat=8'hE4, onum=4. First word osop=1; second word oeop=1; each word 1 cycle after its 4th duobit.
- pDAT_W=8, pMSB_FIRST=1: frame of 3 duobits 3,2,1 with ieop on the 3rd -> single word odat=8'hE4, onum=3, osop=oeop=1.
- Sparse ival (valid every 4th cycle, 7/8-rate-like gaps) with iclkena toggling 50% -> packed data identical to the contiguous case. Outputs frozen while iclkena=0.
- ival without isop in IDLE -> oerr pulse, no oval. Then isop&ieop single duobit 2'b10 -> odat=8'h02, onum=1, osop=oeop=1.
- isop at duobit 3 of an open frame -> oerr=1, no partial word emitted. New frame packs from slot 0 with osop=1 on its first word.
- Async reset asserted mid-frame between iclk edges -> all outputs 0 immediately. Post-reset frame packs correctly from slot 0.

Source files
------------

// File: rtl/rsc2_enc_parity_pack.sv
// ---------------------------------------------------------------------------
// rsc2_enc_parity_pack
//
// Packs the sparse duobit stream left after Y/W puncturing into pDAT_W-bit
// words for the output mux/FIFO. Each word carries a valid-slot count and
// sop/eop framing. Upstream cannot stall, so every word leaves as a single
// oval pulse exactly one enabled cycle after the duobit that completes it
// or ends the frame.
//
// Parameters:
//   pDAT_W     : output word width, even, 2..32 (pDAT_W/2 duobits per word)
//   pMSB_FIRST : 0 -> first duobit at odat[1:0]
//                1 -> first duobit at odat[pDAT_W-1:pDAT_W-2]
//
// Ports:
//   iclk     : clock
//   ireset   : asynchronous active-high reset
//   iclkena  : clock enable, low freezes all state and outputs
//   isop     : first duobit of frame (qualified by ival)
//   ieop     : last duobit of frame (qualified by ival)
//   ival     : duobit valid
//   idat     : duobit, idat[1] lands on the higher bit of its slot
//   oval     : packed word valid pulse
//   osop     : word is first of frame (qualified by oval)
//   oeop     : word is last of frame (qualified by oval)
//   onum     : number of valid duobits in the word (qualified by oval)
//   odat     : packed word, unused slots are zero
//   oerr     : framing error pulse (data outside frame / missing eop)
// ---------------------------------------------------------------------------
module rsc2_enc_parity_pack #(
   parameter int pDAT_W     = 8,
   parameter int pMSB_FIRST = 0
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              iclkena,
   input  logic              isop,
   input  logic              ieop,
   input  logic              ival,
   input  logic [1:0]        idat,
   output logic              oval,
   output logic              osop,
   output logic              oeop,
   output logic [4:0]        onum,
   output logic [pDAT_W-1:0] odat,
   output logic              oerr
);

   typedef enum logic {
      ST_IDLE,
      ST_PACK
   } state_t;

   localparam logic [4:0] NSLOT = 5'(pDAT_W / 2);

   // OR a duobit into its slot. The target slot is always zero in base
   // because the accumulator is cleared after each emitted word and a
   // restarted frame begins from an all-zero word.
   function automatic logic [pDAT_W-1:0] place_slot(
      input logic [pDAT_W-1:0] base,
      input logic [4:0]        slot,
      input logic [1:0]        d
   );
      int sh;
      sh = (pMSB_FIRST != 0) ? (pDAT_W - 2 - 2 * int'(slot)) : (2 * int'(slot));
      return base | (pDAT_W'(d) << sh);
   endfunction

   state_t              state_p0, state_nxt;
   logic [4:0]          cnt_p0, cnt_nxt;
   logic [pDAT_W-1:0]   acc_p0, acc_nxt;
   logic                first_p0, first_nxt;

   logic                oval_nxt, osop_nxt, oeop_nxt, oerr_nxt;
   logic [4:0]          onum_nxt;
   logic [pDAT_W-1:0]   odat_nxt;

   logic                take;
   logic [pDAT_W-1:0]   word;
   logic [4:0]          n;
   logic                first_eff;

   // ---- stage 0: duobit intake, slot placement, word close decision ----
   always_comb begin
      state_nxt = state_p0;
      cnt_nxt   = cnt_p0;
      acc_nxt   = acc_p0;
      first_nxt = first_p0;
      oval_nxt  = 1'b0;
      osop_nxt  = 1'b0;
      oeop_nxt  = 1'b0;
      oerr_nxt  = 1'b0;
      onum_nxt  = onum;
      odat_nxt  = odat;
      take      = 1'b0;
      word      = '0;
      n         = '0;
      first_eff = first_p0;

      if (ival) begin
         if (isop) begin
            // A new sop inside an open frame means the previous eop went
            // missing: drop the partial word silently and flag it.
            oerr_nxt  = (state_p0 == ST_PACK);
            take      = 1'b1;
            word      = place_slot('0, 5'd0, idat);
            n         = 5'd1;
            first_eff = 1'b1;
         end else if (state_p0 == ST_IDLE) begin
            oerr_nxt  = 1'b1;
         end else begin
            take      = 1'b1;
            word      = place_slot(acc_p0, cnt_p0, idat);
            n         = cnt_p0 + 5'd1;
         end

         if (take) begin
            if (ieop || (n == NSLOT)) begin
               oval_nxt  = 1'b1;
               osop_nxt  = first_eff;
               oeop_nxt  = ieop;
               onum_nxt  = n;
               odat_nxt  = word;
               cnt_nxt   = '0;
               acc_nxt   = '0;
               first_nxt = 1'b0;
               state_nxt = ieop ? ST_IDLE : ST_PACK;
            end else begin
               cnt_nxt   = n;
               acc_nxt   = word;
               first_nxt = first_eff;
               state_nxt = ST_PACK;
            end
         end
      end
   end

   // ---- stage 1: registered state and outputs ----
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state_p0 <= ST_IDLE;
         cnt_p0   <= '0;
         acc_p0   <= '0;
         first_p0 <= 1'b0;
         oval     <= 1'b0;
         osop     <= 1'b0;
         oeop     <= 1'b0;
         oerr     <= 1'b0;
         onum     <= '0;
         odat     <= '0;
      end else if (iclkena) begin
         state_p0 <= state_nxt;
         cnt_p0   <= cnt_nxt;
         acc_p0   <= acc_nxt;
         first_p0 <= first_nxt;
         oval     <= oval_nxt;
         osop     <= osop_nxt;
         oeop     <= oeop_nxt;
         oerr     <= oerr_nxt;
         onum     <= onum_nxt;
         odat     <= odat_nxt;
      end
   end

endmodule

// File: tb/tb_rsc2_enc_parity_pack.sv
module tb_rsc2_enc_parity_pack;

   localparam int W  = 8;
   localparam int NS = W / 2;

   logic       iclk    = 1'b0;
   logic       ireset  = 1'b0;
   logic       iclkena = 1'b0;
   logic       isop    = 1'b0;
   logic       ieop    = 1'b0;
   logic       ival    = 1'b0;
   logic [1:0] idat    = 2'b00;

   logic         oval_l, osop_l, oeop_l, oerr_l;
   logic [4:0]   onum_l;
   logic [W-1:0] odat_l;
   logic         oval_m, osop_m, oeop_m, oerr_m;
   logic [4:0]   onum_m;
   logic [W-1:0] odat_m;

   rsc2_enc_parity_pack #(.pDAT_W(W), .pMSB_FIRST(0)) u_lsb (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ieop(ieop),
      .ival(ival), .idat(idat), .oval(oval_l), .osop(osop_l), .oeop(oeop_l),
      .onum(onum_l), .odat(odat_l), .oerr(oerr_l));

   rsc2_enc_parity_pack #(.pDAT_W(W), .pMSB_FIRST(1)) u_msb (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ieop(ieop),
      .ival(ival), .idat(idat), .oval(oval_m), .osop(osop_m), .oeop(oeop_m),
      .onum(onum_m), .odat(odat_m), .oerr(oerr_m));

   always #5 iclk = ~iclk;

   // Reference model: the open frame is a list of duobits; a word is
   // rendered from that list whenever it fills or the frame ends.
   logic       m_oval, m_osop, m_oeop, m_oerr;
   logic [4:0] m_onum;
   logic [7:0] m_dl, m_dm;
   logic [1:0] frm[$];
   bit         m_in, m_first;

   logic [16:0] act_l, act_m, exp_l, exp_m;
   assign act_l = {oval_l, osop_l, oeop_l, oerr_l, onum_l, odat_l};
   assign act_m = {oval_m, osop_m, oeop_m, oerr_m, onum_m, odat_m};
   assign exp_l = {m_oval, m_osop, m_oeop, m_oerr, m_onum, m_dl};
   assign exp_m = {m_oval, m_osop, m_oeop, m_oerr, m_onum, m_dm};

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;

   task automatic model_reset();
      m_oval = 0; m_osop = 0; m_oeop = 0; m_oerr = 0;
      m_onum = 0; m_dl = 0; m_dm = 0;
      frm.delete();
      m_in = 0; m_first = 0;
   endtask

   task automatic model_step(input bit v, input bit s, input bit e, input logic [1:0] d);
      m_oval = 0; m_osop = 0; m_oeop = 0; m_oerr = 0;
      if (!v) return;
      if (s) begin
         if (m_in) m_oerr = 1;
         frm.delete();
         frm.push_back(d);
         m_in = 1;
         m_first = 1;
      end else if (!m_in) begin
         m_oerr = 1;
         return;
      end else begin
         frm.push_back(d);
      end
      if (e || frm.size() == NS) begin
         m_dl = 0;
         m_dm = 0;
         foreach (frm[i]) begin
            m_dl = m_dl | (8'(frm[i]) << (2 * i));
            m_dm = m_dm | (8'(frm[i]) << (W - 2 - 2 * i));
         end
         m_onum  = 5'(frm.size());
         m_oval  = 1;
         m_osop  = m_first;
         m_oeop  = e;
         m_first = 0;
         frm.delete();
         if (e) m_in = 0;
      end
   endtask

   // Called at a negedge: drive inputs, advance through one posedge,
   // return at the following negedge.
   task automatic step(input bit en, input bit v, input bit s, input bit e, input logic [1:0] d);
      iclkena = en; ival = v; isop = s; ieop = e; idat = d;
      @(posedge iclk);
      if (en) model_step(v, s, e, d);
      @(negedge iclk);
      cyc++;
   endtask

   task automatic test_reset();
      #1 ireset = 1'b1;
      #1;
      ntot++;
      if ({act_l, act_m} !== 34'd0)
         $display("FAIL reset_async lsb=%h msb=%h required=0", act_l, act_m);
      else npass++;
      @(negedge iclk);
      ireset = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0, 2'b00);
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL reset_idle cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
      end
   endtask

   task automatic test_contiguous();
      logic [1:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 2'(i % 4);
         step(1, 1, i == 0, i == 7, d);
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL contig cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
         if (i == 3) begin
            ntot++;
            if (!(oval_l && osop_l && !oeop_l && onum_l == 5'd4 && odat_l == 8'hE4))
               $display("FAIL contig_word0 got v%b s%b e%b n%0d d%h required v1 s1 e0 n4 dE4", oval_l, osop_l, oeop_l, onum_l, odat_l);
            else npass++;
         end
         if (i == 7) begin
            ntot++;
            if (!(oval_l && !osop_l && oeop_l && onum_l == 5'd4 && odat_l == 8'hE4))
               $display("FAIL contig_word1 got v%b s%b e%b n%0d d%h required v1 s0 e1 n4 dE4", oval_l, osop_l, oeop_l, onum_l, odat_l);
            else npass++;
         end
      end
      step(1, 0, 0, 0, 2'b00);
      ntot++;
      if (act_l !== exp_l || act_m !== exp_m || oval_l !== 1'b0)
         $display("FAIL contig_after cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
      else npass++;
   endtask

   task automatic test_msb_first();
      logic [1:0] seq [3] = '{2'd3, 2'd2, 2'd1};
      for (int i = 0; i < 3; i++) begin
         step(1, 1, i == 0, i == 2, seq[i]);
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL msb cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
      end
      ntot++;
      if (!(oval_m && osop_m && oeop_m && onum_m == 5'd3 && odat_m == 8'hE4 && odat_l == 8'h1B))
         $display("FAIL msb_word got v%b s%b e%b n%0d dm%h dl%h required v1 s1 e1 n3 dmE4 dl1B", oval_m, osop_m, oeop_m, onum_m, odat_m, odat_l);
      else npass++;
   endtask

   task automatic test_sparse_gated();
      logic [7:0]  wd[$];
      logic [4:0]  wn[$];
      logic [16:0] prev_l;
      bit          en, v;
      int          i, ph, guard;
      i = 0; ph = 0; guard = 0;
      while (i < 8 && guard < 400) begin
         en = 1'($urandom_range(0, 1));
         v  = (ph % 4 == 3);
         prev_l = act_l;
         if (v) step(en, 1, i == 0, i == 7, 2'(i % 4));
         else   step(en, 0, 1'($urandom), 1'($urandom), 2'($urandom));
         if (en && v) i++;
         if (en) ph++;
         guard++;
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL sparse cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
         if (!en) begin
            ntot++;
            if (act_l !== prev_l)
               $display("FAIL sparse_freeze cyc=%0d got=%h required=%h", cyc, act_l, prev_l);
            else npass++;
         end
         if (en && oval_l) begin
            wd.push_back(odat_l);
            wn.push_back(onum_l);
         end
      end
      ntot++;
      if (i < 8) $display("FAIL sparse_timeout consumed=%0d required=8", i);
      else npass++;
      ntot++;
      if (wd.size() != 2 || wd[0] !== 8'hE4 || wd[1] !== 8'hE4 || wn[0] !== 5'd4 || wn[1] !== 5'd4)
         $display("FAIL sparse_words count=%0d required 2 words E4/n4", wd.size());
      else npass++;
   endtask

   task automatic test_err_idle();
      step(1, 1, 0, 0, 2'b11);
      ntot++;
      if (act_l !== exp_l || act_m !== exp_m || !oerr_l || oval_l)
         $display("FAIL err_idle cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
      else npass++;
      step(1, 0, 0, 0, 2'b00);
      ntot++;
      if (act_l !== exp_l || act_m !== exp_m || oerr_l)
         $display("FAIL err_clear cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
      else npass++;
      step(1, 1, 1, 1, 2'b10);
      ntot++;
      if (!(oval_l && osop_l && oeop_l && !oerr_l && onum_l == 5'd1 && odat_l == 8'h02 && odat_m == 8'h80))
         $display("FAIL err_single got v%b s%b e%b n%0d dl%h dm%h required v1 s1 e1 n1 dl02 dm80", oval_l, osop_l, oeop_l, onum_l, odat_l, odat_m);
      else npass++;
   endtask

   task automatic test_restart();
      logic [1:0] d [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      bit         s [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         step(1, 1, s[i], i == 7, d[i]);
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL restart cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
         if (i == 2) begin
            ntot++;
            if (!(oerr_l && !oval_l))
               $display("FAIL restart_err got oerr=%b oval=%b required oerr=1 oval=0", oerr_l, oval_l);
            else npass++;
         end
         if (i == 5) begin
            ntot++;
            if (!(oval_l && osop_l && onum_l == 5'd4 && odat_l == 8'h93))
               $display("FAIL restart_word got v%b s%b n%0d d%h required v1 s1 n4 d93", oval_l, osop_l, onum_l, odat_l);
            else npass++;
         end
      end
   endtask

   task automatic test_random();
      bit en, v, s, e;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         v  = ($urandom_range(0, 4) < 3);
         s  = ($urandom_range(0, 9) == 0);
         e  = ($urandom_range(0, 5) == 0);
         step(en, v, s, e, 2'($urandom));
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL random cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
      end
      step(1, 1, 0, 1, 2'b00);
      step(1, 0, 0, 0, 2'b00);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) step(1, 1, i == 0, 0, 2'(i % 4));
      ntot++;
      if (act_l !== exp_l || odat_l !== 8'hE4)
         $display("FAIL areset_pre got=%h required=%h", act_l, exp_l);
      else npass++;
      #2 ireset = 1'b1;
      #1;
      model_reset();
      ntot++;
      if ({act_l, act_m} !== 34'd0)
         $display("FAIL areset_now lsb=%h msb=%h required=0", act_l, act_m);
      else npass++;
      @(negedge iclk);
      ireset = 1'b0;
      step(1, 1, 0, 1, 2'b01);
      ntot++;
      if (act_l !== exp_l || act_m !== exp_m || !oerr_l || oval_l)
         $display("FAIL areset_nosop cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
      else npass++;
      for (int i = 0; i < 4; i++) begin
         step(1, 1, i == 0, i == 3, (i < 2) ? 2'd2 : 2'd1);
         ntot++;
         if (act_l !== exp_l || act_m !== exp_m)
            $display("FAIL areset_post cyc=%0d lsb=%h exp=%h msb=%h exp=%h", cyc, act_l, exp_l, act_m, exp_m);
         else npass++;
      end
      ntot++;
      if (!(oval_l && osop_l && oeop_l && onum_l == 5'd4 && odat_l == 8'h5A))
         $display("FAIL areset_word got v%b s%b e%b n%0d d%h required v1 s1 e1 n4 d5A", oval_l, osop_l, oeop_l, onum_l, odat_l);
      else npass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_contiguous();
      test_msb_first();
      test_sparse_gated();
      test_err_idle();
      test_restart();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
